game: RTL and testbench

- Turn-based six-player counting game controller ("두모/세모" style).
- Players sit in a ring numbered 1..6, and exactly one player holds the turn.
- Each player presents a 3-bit move value and pulses a per-player button. The block advances the turn, or declares a loser and freezes.
- Sits between player button/switch inputs and the score/display logic.

---
 rtl/game.sv | 154 +++++++++++++++
 tb/tb_game.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game.sv
// Six-player turn-based counting game controller.
// Players 1..6 sit in a ring; the turn holder presents a move value and
// presses their button to advance the turn. Any out-of-turn press or bad
// move ends the game, and the loser is held until reset.
// Optional feature macro: PLAYER_TIMEOUT_EN adds an idle limit of
// TIMEOUT_CYCLES clock cycles for the turn holder.
module game #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] player1,
    input  logic [2:0] player2,
    input  logic [2:0] player3,
    input  logic [2:0] player4,
    input  logic [2:0] player5,
    input  logic [2:0] player6,
    input  logic [5:0] player_btn,
    output logic [2:0] out,
    output logic [3:0] state_out
);

    typedef enum logic {
        PLAY = 1'b0,
        LOSE = 1'b1
    } game_state_t;

    game_state_t state;
    game_state_t next_state;

    logic [2:0] turn;
    logic [2:0] next_turn;
    logic [2:0] loser;
    logic [2:0] next_loser;
    logic [5:0] btn_prev;

    logic [5:0] press;
    logic [5:0] turn_onehot;
    logic [5:0] out_of_turn;
    logic [2:0] out_of_turn_player;
    logic       holder_pressed;
    logic [2:0] holder_move;
    logic [3:0] turn_plus_one;
    logic [3:0] turn_plus_two;
    logic       timeout_hit;

    // A timeout shorter than two cycles would leave no time to press at all.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("game: TIMEOUT_CYCLES must be at least 2");
    end

    // Rising-edge detection, turn-holder decode and out-of-turn priority.
    always_comb begin
        press              = player_btn & ~btn_prev;
        turn_onehot        = 6'b000001 << (turn - 3'd1);
        out_of_turn        = press & ~turn_onehot;
        holder_pressed     = |(press & turn_onehot);
        out_of_turn_player = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (out_of_turn[i]) begin
                out_of_turn_player = 3'(i + 1);
            end
        end
        case (turn)
            3'd1:    holder_move = player1;
            3'd2:    holder_move = player2;
            3'd3:    holder_move = player3;
            3'd4:    holder_move = player4;
            3'd5:    holder_move = player5;
            3'd6:    holder_move = player6;
            default: holder_move = 3'd0;
        endcase
        turn_plus_one = {1'b0, turn} + 4'd1;
        if (turn_plus_one > 4'd6) begin
            turn_plus_one = turn_plus_one - 4'd6;
        end
        turn_plus_two = {1'b0, turn} + 4'd2;
        if (turn_plus_two > 4'd6) begin
            turn_plus_two = turn_plus_two - 4'd6;
        end
    end

`ifdef PLAYER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] idle_count;

    assign timeout_hit = (state == PLAY) && (idle_count == CW'(TIMEOUT_CYCLES - 1));

    // Idle counter restarts whenever the turn moves or the game ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_count <= '0;
        end else if (state != PLAY || next_state != PLAY || next_turn != turn) begin
            idle_count <= '0;
        end else begin
            idle_count <= idle_count + CW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state decision: out-of-turn loss beats the holder's move, and any
    // press beats the idle timeout.
    always_comb begin
        next_state = state;
        next_turn  = turn;
        next_loser = loser;
        if (state == PLAY) begin
            if (|out_of_turn) begin
                next_state = LOSE;
                next_loser = out_of_turn_player;
            end else if (holder_pressed) begin
                case (holder_move)
                    3'd2:    next_turn = turn_plus_one[2:0];
                    3'd1:    next_turn = turn_plus_two[2:0];
                    default: begin
                        next_state = LOSE;
                        next_loser = turn;
                    end
                endcase
            end else if (timeout_hit) begin
                next_state = LOSE;
                next_loser = turn;
            end
        end
    end

    // Game state, edge history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PLAY;
            turn      <= 3'd1;
            loser     <= 3'd0;
            btn_prev  <= 6'd0;
            out       <= 3'd0;
            state_out <= 4'b0001;
        end else begin
            state    <= next_state;
            turn     <= next_turn;
            loser    <= next_loser;
            btn_prev <= player_btn;
            if (next_state == LOSE) begin
                out       <= next_loser;
                state_out <= {1'b1, next_loser};
            end else begin
                out       <= 3'd0;
                state_out <= {1'b0, next_turn};
            end
        end
    end

endmodule

// File: tb/tb_game.sv
// Directed self-checking bench for the six-player game controller.
module tb_game;

    logic       clk;
    logic       reset;
    logic [2:0] player1;
    logic [2:0] player2;
    logic [2:0] player3;
    logic [2:0] player4;
    logic [2:0] player5;
    logic [2:0] player6;
    logic [5:0] player_btn;
    logic [2:0] out;
    logic [3:0] state_out;

    int total;
    int bad;

    game #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .player1(player1),
        .player2(player2),
        .player3(player3),
        .player4(player4),
        .player5(player5),
        .player6(player6),
        .player_btn(player_btn),
        .out(out),
        .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        player_btn = 6'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Press with the given mask for one cycle, then release for one cycle.
    task automatic press(input logic [5:0] mask);
        @(negedge clk);
        player_btn = mask;
        @(negedge clk);
        player_btn = 6'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (state_out !== 4'b0001 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_held: state_out=%b out=%b want 0001/000", state_out, out);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        total++;
        if (state_out !== 4'b0001 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_release: state_out=%b out=%b want 0001/000", state_out, out);
        end
    endtask

    task automatic test_advance();
        do_reset();
        player1 = 3'd2;
        player2 = 3'd1;
        press(6'b000001);
        total++;
        if (state_out !== 4'b0010 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL advance_p1: state_out=%b out=%b want 0010/000", state_out, out);
        end
        press(6'b000010);
        total++;
        if (state_out !== 4'b0100 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL skip_p2: state_out=%b out=%b want 0100/000", state_out, out);
        end
    endtask

    task automatic test_out_of_turn();
        press(6'b000100);
        total++;
        if (state_out !== 4'b1011 || out !== 3'b011) begin
            bad++;
            $display("[TB] FAIL out_of_turn: state_out=%b out=%b want 1011/011", state_out, out);
        end
        press(6'b000100);
        press(6'b001000);
        total++;
        if (state_out !== 4'b1011 || out !== 3'b011) begin
            bad++;
            $display("[TB] FAIL lose_frozen: state_out=%b out=%b want 1011/011", state_out, out);
        end
    endtask

    task automatic test_holder_loss();
        do_reset();
        player1 = 3'd3;
        press(6'b000001);
        total++;
        if (state_out !== 4'b1001 || out !== 3'b001) begin
            bad++;
            $display("[TB] FAIL holder_v3: state_out=%b out=%b want 1001/001", state_out, out);
        end
        do_reset();
        player1 = 3'd0;
        press(6'b000001);
        total++;
        if (state_out !== 4'b1001 || out !== 3'b001) begin
            bad++;
            $display("[TB] FAIL holder_v0: state_out=%b out=%b want 1001/001", state_out, out);
        end
        do_reset();
        player1 = 3'd2;
        player2 = 3'd7;
        press(6'b000001);
        press(6'b000010);
        total++;
        if (state_out !== 4'b1010 || out !== 3'b010) begin
            bad++;
            $display("[TB] FAIL holder_v7: state_out=%b out=%b want 1010/010", state_out, out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        player1 = 3'd2; player2 = 3'd2; player3 = 3'd2;
        player4 = 3'd2; player5 = 3'd2; player6 = 3'd2;
        press(6'b000001);
        press(6'b000010);
        press(6'b000100);
        press(6'b001000);
        press(6'b010000);
        total++;
        if (state_out !== 4'b0110 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reach_turn6: state_out=%b out=%b want 0110/000", state_out, out);
        end
        press(6'b100000);
        total++;
        if (state_out !== 4'b0001 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL wrap_6plus1: state_out=%b out=%b want 0001/000", state_out, out);
        end
        do_reset();
        player1 = 3'd2; player2 = 3'd1; player4 = 3'd2; player5 = 3'd1;
        press(6'b000001);
        press(6'b000010);
        press(6'b001000);
        total++;
        if (state_out !== 4'b0101) begin
            bad++;
            $display("[TB] FAIL reach_turn5: state_out=%b want 0101", state_out);
        end
        press(6'b010000);
        total++;
        if (state_out !== 4'b0001 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL wrap_5plus2: state_out=%b out=%b want 0001/000", state_out, out);
        end
        do_reset();
        player1 = 3'd1; player3 = 3'd1; player5 = 3'd2; player6 = 3'd1;
        press(6'b000001);
        press(6'b000100);
        press(6'b010000);
        press(6'b100000);
        total++;
        if (state_out !== 4'b0010 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL wrap_6plus2: state_out=%b out=%b want 0010/000", state_out, out);
        end
    endtask

    task automatic test_hold();
        do_reset();
        player1 = 3'd2;
        @(negedge clk);
        player_btn = 6'b000001;
        idle(5);
        total++;
        if (state_out !== 4'b0010 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL hold_once: state_out=%b out=%b want 0010/000", state_out, out);
        end
        @(negedge clk);
        player_btn = 6'd0;
        idle(1);
    endtask

    task automatic test_simultaneous();
        do_reset();
        player1 = 3'd2;
        press(6'b100101);
        total++;
        if (state_out !== 4'b1011 || out !== 3'b011) begin
            bad++;
            $display("[TB] FAIL simultaneous: state_out=%b out=%b want 1011/011", state_out, out);
        end
    endtask

    task automatic test_mid_reset();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (state_out !== 4'b0001 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL async_reset_in_lose: state_out=%b out=%b want 0001/000", state_out, out);
        end
        @(negedge clk);
        reset = 1'b0;
        player1 = 3'd2;
        press(6'b000001);
        total++;
        if (state_out !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL play_after_reset: state_out=%b want 0010", state_out);
        end
    endtask

`ifdef PLAYER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        idle(7);
        total++;
        if (state_out !== 4'b0001 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL timeout_early: state_out=%b out=%b want 0001/000", state_out, out);
        end
        idle(1);
        total++;
        if (state_out !== 4'b1001 || out !== 3'b001) begin
            bad++;
            $display("[TB] FAIL timeout_fire: state_out=%b out=%b want 1001/001", state_out, out);
        end
        do_reset();
        idle(4);
        do_reset();
        total++;
        if (state_out !== 4'b0001 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL timeout_reset: state_out=%b out=%b want 0001/000", state_out, out);
        end
        idle(7);
        total++;
        if (state_out !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL timeout_cleared: state_out=%b want 0001", state_out);
        end
    endtask
`else
    task automatic test_timeout();
        do_reset();
        idle(30);
        total++;
        if (state_out !== 4'b0001 || out !== 3'b000) begin
            bad++;
            $display("[TB] FAIL no_time_limit: state_out=%b out=%b want 0001/000", state_out, out);
        end
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        player_btn = 6'd0;
        player1 = 3'd0; player2 = 3'd0; player3 = 3'd0;
        player4 = 3'd0; player5 = 3'd0; player6 = 3'd0;
        test_reset();
        test_advance();
        test_out_of_turn();
        test_holder_loss();
        test_wrap();
        test_hold();
        test_simultaneous();
        test_mid_reset();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
